// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity modes, receiver states and
// parameter helpers used at elaboration time.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

  function automatic bit rx_params_ok(input int div, input int oversample,
                                      input int data_bits, input int parity,
                                      input int stop_bits);
    return (div >= 1) && (oversample >= 4) && (oversample % 2 == 0) &&
           (data_bits >= 5) && (data_bits <= 9) &&
           (parity >= PARITY_NONE) && (parity <= PARITY_ODD) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clock_fpga,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock_fpga) begin
    if (!reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver with majority voting, glitch rejection,
// framing/parity error flags and a valid/ready holding register.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock_fpga,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] IDX_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] IDX_M1   = SW'(MID - 1);
  localparam logic [SW-1:0] IDX_MID  = SW'(MID);
  localparam logic [SW-1:0] IDX_DEC  = SW'(MID + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (!rx_params_ok(DIV, OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS)) begin : g_bad_params
    $error("uart_rx_oversample: illegal DIV/OVERSAMPLE/DATA_BITS/PARITY/STOP_BITS");
  end

  rx_state_t            state, state_next;
  logic                 tick;
  logic                 sync_ff1, rxd_s;
  logic [SW-1:0]        samp_cnt, samp_idx;
  logic [3:0]           bit_cnt;
  logic                 vote_m1, vote_mid, bit_val;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 frame_pend, par_pend, par_expect;
  logic                 start_seen, decide, complete, accept, drop;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clock_fpga (clock_fpga),
    .reset      (reset),
    .tick       (tick)
  );

  always_ff @(posedge clock_fpga) begin
    if (!reset) begin
      sync_ff1 <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      sync_ff1 <= rxd;
      rxd_s    <= sync_ff1;
    end
  end

  // The detection tick is sample index 0; samp_idx is the index of the current tick.
  assign samp_idx   = (samp_cnt == IDX_LAST) ? '0 : samp_cnt + 1'b1;
  assign start_seen = tick && (state == ST_IDLE) && !rxd_s;
  assign decide     = tick && (state != ST_IDLE) && (samp_idx == IDX_DEC);
  assign bit_val    = (vote_m1 & vote_mid) | (vote_m1 & rxd_s) | (vote_mid & rxd_s);
  assign complete   = decide && (state == ST_STOP) && (bit_cnt == STOP_LAST);
  assign accept     = rx_valid & rx_ready;
  assign drop       = complete & rx_valid & ~rx_ready;
  assign busy       = (state != ST_IDLE);
  assign par_expect = (PARITY == PARITY_ODD) ? ~^shift_reg : ^shift_reg;

  always_ff @(posedge clock_fpga) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // a path that left state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_seen) state_next = ST_START;
      ST_START:  if (decide) state_next = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (decide && (bit_cnt == DATA_LAST))
                   state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (decide) state_next = ST_STOP;
      ST_STOP:   if (complete) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_fpga) begin
    if (!reset) begin
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      vote_m1    <= 1'b1;
      vote_mid   <= 1'b1;
      shift_reg  <= '0;
      frame_pend <= 1'b0;
      par_pend   <= 1'b0;
    end else if (start_seen) begin
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      frame_pend <= 1'b0;
      par_pend   <= 1'b0;
    end else if (tick && (state != ST_IDLE)) begin
      samp_cnt <= samp_idx;
      if (samp_idx == IDX_M1)  vote_m1  <= rxd_s;
      if (samp_idx == IDX_MID) vote_mid <= rxd_s;
      if (decide) begin
        bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
        if (state == ST_DATA)   shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
        if ((state == ST_PARITY) && (bit_val != par_expect)) par_pend <= 1'b1;
        if ((state == ST_STOP) && !bit_val) frame_pend <= 1'b1;
      end
    end
  end

  // Holding register: a completing frame loads if the slot is free or being
  // emptied this cycle, otherwise it is dropped and flagged as an overrun.
  always_ff @(posedge clock_fpga) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (complete && (!rx_valid || rx_ready)) begin
        rx_data    <= shift_reg;
        rx_valid   <= 1'b1;
        frame_err  <= frame_pend | ~bit_val;
        parity_err <= par_pend;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end

      if (drop) begin
        overrun_err <= 1'b1;
      end else if (accept) begin
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench: three receiver instances (8N1/4x, even parity/4x,
// 8N1/16x) driven with directed and random frames, scored against a word model.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  localparam int CLK_FREQ  = 16_000_000;
  localparam int BAUD_RATE = 1_000_000;
  localparam int BIT_CYC   = 16;  // clocks per bit for every instance

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } word_t;

  logic clock_fpga = 1'b0;
  logic reset      = 1'b0;
  always #5 clock_fpga = ~clock_fpga;

  logic line = 1'b1;
  int   sel  = 0;
  logic rxd_a, rxd_b, rxd_c;
  assign rxd_a = (sel == 0) ? line : 1'b1;
  assign rxd_b = (sel == 1) ? line : 1'b1;
  assign rxd_c = (sel == 2) ? line : 1'b1;

  logic       rx_ready_a = 1'b1, rx_ready_b = 1'b1, rx_ready_c = 1'b1;
  logic [7:0] rx_data_a, rx_data_b, rx_data_c;
  logic       rx_valid_a, rx_valid_b, rx_valid_c;
  logic       frame_err_a, frame_err_b, frame_err_c;
  logic       parity_err_a, parity_err_b, parity_err_c;
  logic       overrun_err_a, overrun_err_b, overrun_err_c;
  logic       busy_a, busy_b, busy_c;

  uart_rx_oversample #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(4),
                       .DATA_BITS(8), .PARITY(uart_pkg::PARITY_NONE), .STOP_BITS(1)) dut_a (
    .clock_fpga(clock_fpga), .reset(reset), .rxd(rxd_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .frame_err(frame_err_a),
    .parity_err(parity_err_a), .overrun_err(overrun_err_a), .busy(busy_a));

  uart_rx_oversample #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(4),
                       .DATA_BITS(8), .PARITY(uart_pkg::PARITY_EVEN), .STOP_BITS(1)) dut_b (
    .clock_fpga(clock_fpga), .reset(reset), .rxd(rxd_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .frame_err(frame_err_b),
    .parity_err(parity_err_b), .overrun_err(overrun_err_b), .busy(busy_b));

  uart_rx_oversample #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(16),
                       .DATA_BITS(8), .PARITY(uart_pkg::PARITY_NONE), .STOP_BITS(1)) dut_c (
    .clock_fpga(clock_fpga), .reset(reset), .rxd(rxd_c), .rx_data(rx_data_c),
    .rx_valid(rx_valid_c), .rx_ready(rx_ready_c), .frame_err(frame_err_c),
    .parity_err(parity_err_c), .overrun_err(overrun_err_c), .busy(busy_c));

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t exp_q[3][$];
  int    valid_cyc[3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic score(input int id, input logic [7:0] d, input logic fe, input logic pe);
    word_t e;
    if (exp_q[id].size() == 0) begin
      check($sformatf("dut%0d unexpected word 0x%0h", id, d), 32'(exp_q[id].size()), 32'd1);
      return;
    end
    e = exp_q[id].pop_front();
    check($sformatf("dut%0d rx_data", id), 32'(d), 32'(e.data));
    check($sformatf("dut%0d frame_err", id), 32'(fe), 32'(e.fe));
    check($sformatf("dut%0d parity_err", id), 32'(pe), 32'(e.pe));
  endtask

  // Handshakes are observed mid-cycle; inputs only change just after posedge.
  always @(negedge clock_fpga) begin
    if (rx_valid_a) valid_cyc[0]++;
    if (rx_valid_b) valid_cyc[1]++;
    if (rx_valid_c) valid_cyc[2]++;
    if (rx_valid_a && rx_ready_a) score(0, rx_data_a, frame_err_a, parity_err_a);
    if (rx_valid_b && rx_ready_b) score(1, rx_data_b, frame_err_b, parity_err_b);
    if (rx_valid_c && rx_ready_c) score(2, rx_data_c, frame_err_c, parity_err_c);
  end

  // Serialises one frame onto instance `id`, followed by two idle bit times.
  // spike_off >= 0 inverts one clock of every data bit at that offset;
  // reset_bit >= 0 pulses reset during that frame bit (0 = start bit).
  task automatic send(input int id, input logic [7:0] data, input bit has_par,
                      input bit par_bit, input bit stop_val, input int spike_off,
                      input int reset_bit, input bit expect_word);
    logic bits[$];
    word_t w;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (has_par) bits.push_back(par_bit);
    bits.push_back(stop_val);
    if (expect_word) begin
      w.data = data;
      w.fe   = ~stop_val;
      w.pe   = has_par ? ((^data) != par_bit) : 1'b0;
      exp_q[id].push_back(w);
    end
    sel = id;
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < BIT_CYC; c++) begin
        @(posedge clock_fpga); #1;
        line = bits[b] ^ ((spike_off == c) && (b >= 1) && (b <= 8));
        if ((b == reset_bit) && (c == 4)) reset = 1'b0;
        if ((b == reset_bit) && (c == 8)) reset = 1'b1;
      end
    end
    @(posedge clock_fpga); #1;
    line = 1'b1;
    repeat (2 * BIT_CYC) @(posedge clock_fpga);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base;
    bit  saw_busy;
    logic [7:0] d;
    bit  stop_ok, pbit;

    repeat (5) @(posedge clock_fpga);
    #1;
    check("reset rx_valid_a", 32'(rx_valid_a), 32'd0);
    check("reset busy_a", 32'(busy_a), 32'd0);
    check("reset rx_data_a", 32'(rx_data_a), 32'd0);
    check("reset errs_a", {29'd0, frame_err_a, parity_err_a, overrun_err_a}, 32'd0);
    check("reset rx_valid_b", 32'(rx_valid_b), 32'd0);
    check("reset busy_c", 32'(busy_c), 32'd0);
    reset = 1'b1;
    repeat (8) @(posedge clock_fpga);
    #1;

    // Clean 8N1 word, held valid for exactly one cycle with rx_ready high.
    base = valid_cyc[0];
    send(0, 8'hA5, 0, 0, 1, -1, -1, 1);
    check("clean valid cycles", 32'(valid_cyc[0] - base), 32'd1);
    check("clean drained", 32'(exp_q[0].size()), 32'd0);

    // Start glitch: line low for exactly one tick period.
    base = valid_cyc[0];
    sel = 0;
    saw_busy = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock_fpga); #1;
      line = 1'b0;
    end
    @(posedge clock_fpga); #1;
    line = 1'b1;
    for (int c = 0; c < BIT_CYC; c++) begin
      @(posedge clock_fpga); #1;
      if (busy_a) saw_busy = 1;
    end
    check("glitch detected as start", 32'(saw_busy), 32'd1);
    check("glitch busy cleared", 32'(busy_a), 32'd0);
    repeat (BIT_CYC) @(posedge clock_fpga);
    #1;
    check("glitch no word", 32'(valid_cyc[0] - base), 32'd0);

    // Even parity: 0x3C has even weight, so parity bit 1 is wrong, 0 is right.
    send(1, 8'h3C, 1, 1, 1, -1, -1, 1);
    send(1, 8'h3C, 1, 0, 1, -1, -1, 1);
    check("parity drained", 32'(exp_q[1].size()), 32'd0);

    // Framing error then a clean frame.
    send(0, 8'h55, 0, 0, 0, -1, -1, 1);
    send(0, 8'h0F, 0, 0, 1, -1, -1, 1);
    check("frame drained", 32'(exp_q[0].size()), 32'd0);

    // Overrun: second frame dropped while the first is held.
    rx_ready_a = 1'b0;
    send(0, 8'h11, 0, 0, 1, -1, -1, 1);
    send(0, 8'h22, 0, 0, 1, -1, -1, 0);
    check("overrun rx_valid held", 32'(rx_valid_a), 32'd1);
    check("overrun rx_data kept", 32'(rx_data_a), 32'h11);
    check("overrun flag set", 32'(overrun_err_a), 32'd1);
    rx_ready_a = 1'b1;
    repeat (2) @(posedge clock_fpga);
    #1;
    check("overrun accepted rx_valid", 32'(rx_valid_a), 32'd0);
    check("overrun flag cleared", 32'(overrun_err_a), 32'd0);
    check("overrun drained", 32'(exp_q[0].size()), 32'd0);

    // 16x oversampling with a one-sample spike in the middle of every data bit.
    send(2, 8'hC3, 0, 0, 1, 8, -1, 1);
    check("spike drained", 32'(exp_q[2].size()), 32'd0);

    // Reset during data bit 4 of 0xF0 (remaining bits are 1, no false start).
    base = valid_cyc[0];
    send(0, 8'hF0, 0, 0, 1, -1, 5, 0);
    check("reset mid-frame no word", 32'(valid_cyc[0] - base), 32'd0);
    check("reset mid-frame idle", 32'(busy_a), 32'd0);
    send(0, 8'h7E, 0, 0, 1, -1, -1, 1);
    check("post-reset drained", 32'(exp_q[0].size()), 32'd0);

    // Randomised traffic on all three instances.
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(255));
      stop_ok = ($urandom_range(3) != 0);
      send(0, d, 0, 0, stop_ok, -1, -1, 1);
    end
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(255));
      pbit = 1'($urandom_range(1));
      send(1, d, 1, pbit, 1, -1, -1, 1);
    end
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(255));
      send(2, d, 0, 0, 1, $urandom_range(15), -1, 1);
    end
    check("random drained a", 32'(exp_q[0].size()), 32'd0);
    check("random drained b", 32'(exp_q[1].size()), 32'd0);
    check("random drained c", 32'(exp_q[2].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
